vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates a single-port frame-buffer RAM among display reads, a full-screen clear and queued game writes.
// Port ownership is fixed priority: display > clear > write queue. RAM control is combinational; the read return is registered.
module vram_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  vga_row,
  input  logic [9:0]  vga_col,
  input  logic        vga_rdn,
  output logic [11:0] vga_dout,
  input  logic        wr_req,
  input  logic [18:0] wr_addr,
  input  logic [11:0] wr_data,
  output logic        wr_ready,
  input  logic        clr_start,
  input  logic [11:0] clr_color,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [18:0] ram_addr,
  output logic        ram_we,
  output logic [11:0] ram_wdata,
  input  logic [11:0] ram_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [18:0] NUM_WORDS = 19'(H_RES * V_RES);
  localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);
  localparam logic [18:0] HRES_BITS = 19'(H_RES);

  typedef enum logic {IDLE, CLEAR} state_t;

  // Display address: row*H_RES as a sum of shifted rows, one term per set bit of H_RES.
  logic [18:0] row_ext;
  logic [18:0] acc [0:19];
  logic [18:0] disp_addr;
  logic        disp_in_range;
  logic        disp_own;

  assign row_ext = {10'd0, vga_row};
  assign acc[0]  = 19'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 19; gi++) begin : g_mul
      if (HRES_BITS[gi]) begin : g_add
        assign acc[gi+1] = acc[gi] + (row_ext << gi);
      end else begin : g_pass
        assign acc[gi+1] = acc[gi];
      end
    end
  endgenerate

  assign disp_addr     = acc[19] + {9'd0, vga_col};
  assign disp_in_range = ({23'd0, vga_row} < 32'(V_RES)) && ({22'd0, vga_col} < 32'(H_RES));
  assign disp_own      = rst_n && !vga_rdn && disp_in_range;

  // Display read return
  logic rd_flag_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_flag_reg <= 1'b0;
    else        rd_flag_reg <= disp_own;
  end

  assign vga_dout = rd_flag_reg ? ram_rdata : 12'd0;

  // Clear FSM
  state_t      state_reg, state_next;
  logic [18:0] clr_ptr_reg, clr_ptr_next;
  logic [11:0] clr_color_reg, clr_color_next;
  logic        clr_done_reg, clr_done_next;
  logic        clr_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      clr_ptr_reg   <= 19'd0;
      clr_color_reg <= 12'd0;
      clr_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_ptr_reg   <= clr_ptr_next;
      clr_color_reg <= clr_color_next;
      clr_done_reg  <= clr_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_ptr_next   = clr_ptr_reg;
    clr_color_next = clr_color_reg;
    clr_done_next  = 1'b0;
    clr_write      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_start) begin
          state_next     = CLEAR;
          clr_ptr_next   = 19'd0;
          clr_color_next = clr_color;
        end
      end
      CLEAR: begin
        // Display-owned cycles leave the pointer where it is.
        if (!disp_own) begin
          clr_write = 1'b1;
          if (clr_ptr_reg == LAST_ADDR) begin
            state_next    = IDLE;
            clr_done_next = 1'b1;
          end else begin
            clr_ptr_next = clr_ptr_reg + 19'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr_busy = (state_reg == CLEAR);
  assign clr_done = clr_done_reg;

  // Write queue
  logic [18:0]   q_addr_mem [FIFO_DEPTH];
  logic [11:0]   q_data_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          q_push, q_pop;
  logic [18:0]   head_addr;
  logic [11:0]   head_data;
  logic          head_valid;

  assign wr_ready   = (count_reg != CW'(FIFO_DEPTH));
  assign q_push     = wr_req && wr_ready;
  assign q_pop      = rst_n && !disp_own && (state_reg == IDLE) && (count_reg != CW'(0));
  assign head_addr  = q_addr_mem[rd_ptr_reg];
  assign head_data  = q_data_mem[rd_ptr_reg];
  assign head_valid = (head_addr < NUM_WORDS);

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_addr_mem[wr_ptr_reg] <= wr_addr;
      q_data_mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (q_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (q_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (q_push && !q_pop)      count_reg <= count_reg + CW'(1);
      else if (q_pop && !q_push) count_reg <= count_reg - CW'(1);
    end
  end

  // RAM port mux; the address is held when nobody owns the port.
  logic [18:0] last_addr_reg;

  always_comb begin
    ram_addr  = last_addr_reg;
    ram_we    = 1'b0;
    ram_wdata = 12'd0;
    if (!rst_n) begin
      ram_addr = 19'd0;
    end else if (disp_own) begin
      ram_addr = disp_addr;
    end else if (clr_write) begin
      ram_addr  = clr_ptr_reg;
      ram_we    = 1'b1;
      ram_wdata = clr_color_reg;
    end else if (q_pop && head_valid) begin
      ram_addr  = head_addr;
      ram_we    = 1'b1;
      ram_wdata = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_addr_reg <= 19'd0;
    else        last_addr_reg <= ram_addr;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter on a small 16x8 frame: external RAM model plus a queue-based reference
// that predicts every RAM port cycle, the read return and the frame-buffer contents.
module tb_vram_arbiter;
  localparam int H = 16;
  localparam int V = 8;
  localparam int D = 4;
  localparam int WORDS = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  vga_row = '0;
  logic [9:0]  vga_col = '0;
  logic        vga_rdn = 1'b1;
  logic [11:0] vga_dout;
  logic        wr_req = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ready;
  logic        clr_start = 1'b0;
  logic [11:0] clr_color = '0;
  logic        clr_busy, clr_done;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  vram_arbiter #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_row(vga_row), .vga_col(vga_col), .vga_rdn(vga_rdn), .vga_dout(vga_dout),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pattern(int i);
    if (i == 18) return 12'hABC;
    return 12'((i * 467 + 7) & 'hFFF);
  endfunction

  // External single-port synchronous RAM
  logic [11:0] ram [0:WORDS-1];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= pattern(i);
    end else if (ram_we && ram_addr < 19'(WORDS)) begin
      ram[ram_addr[6:0]] <= ram_wdata;
    end
    ram_rdata <= (ram_addr < 19'(WORDS)) ? ram[ram_addr[6:0]] : 12'h000;
  end

  // Reference model state
  logic [11:0] m_mem [WORDS];
  logic [30:0] q[$];
  bit          m_clearing = 0;
  int          m_clr_idx = 0;
  logic [11:0] m_clr_col = '0;
  bit          m_done = 0;
  bit          m_rd_valid = 0;
  logic [11:0] m_rd_val = '0;
  logic [18:0] m_last_addr = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic rdn, logic [8:0] row, logic [9:0] col, logic wrq,
                       logic [18:0] wa, logic [11:0] wd, logic cs, logic [11:0] cc);
    vga_rdn = rdn; vga_row = row; vga_col = col;
    wr_req = wrq; wr_addr = wa; wr_data = wd;
    clr_start = cs; clr_color = cc;
  endtask

  task automatic idle();
    drive(1'b1, 9'd0, 10'd0, 1'b0, 19'd0, 12'd0, 1'b0, 12'd0);
  endtask

  // One clock: entered just after a falling edge with inputs applied, leaves at the next falling edge.
  task automatic cycle();
    bit disp, was_clr, full;
    logic we_e;
    logic [18:0] a_e;
    logic [11:0] d_e;
    logic [30:0] head;
    #1;
    disp = !vga_rdn && int'(vga_row) < V && int'(vga_col) < H;
    we_e = 1'b0; d_e = '0; a_e = m_last_addr;
    if (disp) begin
      a_e = 19'(int'(vga_row) * H + int'(vga_col));
    end else if (m_clearing) begin
      we_e = 1'b1; a_e = 19'(m_clr_idx); d_e = m_clr_col;
    end else if (q.size() > 0) begin
      head = q[0];
      if (int'(head[30:12]) < WORDS) begin
        we_e = 1'b1; a_e = head[30:12]; d_e = head[11:0];
      end
    end
    chk("ram_we", 32'(ram_we), 32'(we_e));
    chk("ram_addr", 32'(ram_addr), 32'(a_e));
    chk("ram_wdata", 32'(ram_wdata), 32'(d_e));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() < D));
    chk("clr_busy", 32'(clr_busy), 32'(m_clearing));
    chk("clr_done", 32'(clr_done), 32'(m_done));
    chk("vga_dout", 32'(vga_dout), m_rd_valid ? 32'(m_rd_val) : 32'd0);
    @(posedge clk);
    m_rd_valid = disp;
    if (disp) m_rd_val = m_mem[a_e[6:0]];
    if (we_e) m_mem[a_e[6:0]] = d_e;
    was_clr = m_clearing;
    full = (q.size() >= D);
    if (!disp && !was_clr && q.size() > 0) void'(q.pop_front());
    if (wr_req && !full) q.push_back({wr_addr, wr_data});
    m_done = 0;
    if (was_clr) begin
      if (!disp) begin
        if (m_clr_idx == WORDS - 1) begin m_clearing = 0; m_done = 1; end
        else m_clr_idx++;
      end
    end else if (clr_start) begin
      m_clearing = 1; m_clr_idx = 0; m_clr_col = clr_color;
    end
    m_last_addr = a_e;
    @(negedge clk);
  endtask

  task automatic reset_outputs_chk(string tag);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    chk({tag, "_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_busy"}, 32'(clr_busy), 32'd0);
    chk({tag, "_done"}, 32'(clr_done), 32'd0);
    chk({tag, "_dout"}, 32'(vga_dout), 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_clearing = 0; m_done = 0; m_rd_valid = 0; m_last_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) m_mem[i] = pattern(i);

    // Reset held with a visible display request and pending inputs
    drive(1'b0, 9'd1, 10'd2, 1'b1, 19'd7, 12'h777, 1'b1, 12'h0AA);
    repeat (3) @(negedge clk);
    #1 reset_outputs_chk("rst");
    @(negedge clk);
    preload = 1'b0;
    rst_n = 1'b1;
    idle();
    cycle();

    // Display read at row 1, col 2; returned data one cycle later
    drive(1'b0, 9'd1, 10'd2, 1'b0, 19'd0, 12'd0, 1'b0, 12'd0);
    cycle();
    idle(); cycle();
    chk("abc_returned_model", 32'(m_mem[18]), 32'hABC);

    // Out-of-range requests
    drive(1'b0, 9'd8, 10'd0, 1'b0, 19'd0, 12'd0, 1'b0, 12'd0); cycle();
    drive(1'b0, 9'd0, 10'd16, 1'b0, 19'd0, 12'd0, 1'b0, 12'd0); cycle();
    idle(); cycle();

    // Queue fill under continuous display, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 9'd2, 10'(i), 1'b1, 19'(10 + i), 12'(12'h100 + i), 1'b0, 12'd0);
      cycle();
    end
    drive(1'b0, 9'd3, 10'd0, 1'b0, 19'd0, 12'd0, 1'b0, 12'd0); cycle();
    chk("fill_not_ready", 32'(wr_ready), 32'd0);
    idle();
    for (int i = 0; i < 5; i++) cycle();

    // Contention with alternating display requests
    drive(1'b0, 9'd4, 10'd1, 1'b1, 19'd20, 12'h2A0, 1'b0, 12'd0); cycle();
    drive(1'b0, 9'd4, 10'd2, 1'b1, 19'd21, 12'h2A1, 1'b0, 12'd0); cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1'(i % 2 == 1), 9'd5, 10'(i), 1'b0, 19'd0, 12'd0, 1'b0, 12'd0);
      cycle();
    end

    // Out-of-range queued write is discarded
    drive(1'b1, 9'd0, 10'd0, 1'b1, 19'd200, 12'hFFF, 1'b0, 12'd0); cycle();
    drive(1'b1, 9'd0, 10'd0, 1'b1, 19'd30, 12'h555, 1'b0, 12'd0); cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();

    // Full clear with a restart attempt, a queued write and a short display stall
    drive(1'b1, 9'd0, 10'd0, 1'b0, 19'd0, 12'd0, 1'b1, 12'hF00); cycle();
    for (int n = 0; n < 2000 && m_clearing; n++) begin
      idle();
      if (n == 20) begin clr_start = 1'b1; clr_color = 12'h0F0; end
      if (n == 30) begin wr_req = 1'b1; wr_addr = 19'd5; wr_data = 12'h123; end
      if (n >= 50 && n < 56) begin vga_rdn = 1'b0; vga_row = 9'(n - 50); vga_col = 10'd3; end
      cycle();
    end
    chk("clr_end_busy", 32'(clr_busy), 32'd0);
    idle();
    for (int i = 0; i < 4; i++) cycle();
    chk("queued_during_clear", 32'(ram[5]), 32'h123);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 1)), 9'($urandom_range(0, 9)), 10'($urandom_range(0, 17)),
            1'($urandom_range(0, 2) != 0), 19'($urandom_range(0, WORDS + 12)), 12'($urandom),
            1'($urandom_range(0, 299) == 0), 12'($urandom));
      cycle();
    end
    idle();
    for (int n = 0; n < 1000 && (m_clearing || q.size() > 0); n++) cycle();
    chk("drain_busy", 32'(clr_busy), 32'd0);
    chk("drain_ready", 32'(wr_ready), 32'd1);

    // Reset mid-clear with writes queued
    drive(1'b1, 9'd0, 10'd0, 1'b0, 19'd0, 12'd0, 1'b1, 12'h00F); cycle();
    for (int n = 0; n < 500 && m_clr_idx < 60; n++) begin
      idle();
      if (n < 2) begin wr_req = 1'b1; wr_addr = 19'(40 + n); wr_data = 12'h3C0; end
      cycle();
    end
    chk("pre_reset_busy", 32'(clr_busy), 32'd1);
    rst_n = 1'b0;
    drive(1'b0, 9'd1, 10'd2, 1'b1, 19'd3, 12'h333, 1'b0, 12'd0);
    #1 reset_outputs_chk("midrst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("midrst_hold_we", 32'(ram_we), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle();
    for (int i = 0; i < 10; i++) cycle();

    // Frame-buffer contents against the reference
    for (int i = 0; i < WORDS; i++) chk($sformatf("mem[%0d]", i), 32'(ram[i]), 32'(m_mem[i]));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
